// File: rtl/kamus_pkg.sv
// kamus_pkg: shared operation codes, writeback selects, memory-stage FSM states and memory-op decode helpers.
package kamus_pkg;

    typedef enum logic [5:0] {
        OP_NOP  = 6'h00,
        OP_ADD  = 6'h01,
        OP_SUB  = 6'h02,
        OP_AND  = 6'h03,
        OP_OR   = 6'h04,
        OP_XOR  = 6'h05,
        OP_SLL  = 6'h06,
        OP_SRL  = 6'h07,
        OP_SRA  = 6'h08,
        OP_SLT  = 6'h09,
        OP_SLTU = 6'h0A,
        OP_LUI  = 6'h0B,
        OP_JAL  = 6'h0C,
        OP_JALR = 6'h0D,
        OP_LB   = 6'h10,
        OP_LH   = 6'h11,
        OP_LW   = 6'h12,
        OP_LBU  = 6'h13,
        OP_LHU  = 6'h14,
        OP_SB   = 6'h18,
        OP_SH   = 6'h19,
        OP_SW   = 6'h1A
    } operation_e;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef logic [1:0] mem_state_t;
    localparam mem_state_t ST_IDLE = 2'd0;
    localparam mem_state_t ST_REQ  = 2'd1;
    localparam mem_state_t ST_RSP  = 2'd2;

    function automatic logic is_load(operation_e op);
        return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
    endfunction

    function automatic logic is_store(operation_e op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic logic is_misaligned(operation_e op, logic [1:0] off);
        return ((op == OP_LW || op == OP_SW) && off != 2'b00) ||
               ((op == OP_LH || op == OP_LHU || op == OP_SH) && off[0]);
    endfunction

endpackage

// File: rtl/kamus_lsu_align.sv
// kamus_lsu_align: combinational store lane/byte-enable alignment and load extraction with sign/zero extension.
// Ports: st_op/st_off/rs2 -> be/wdata (store side); ld_op/ld_off/rdata -> load_data (load side).
module kamus_lsu_align
    import kamus_pkg::*;
(
    input  operation_e  st_op,
    input  logic [1:0]  st_off,
    input  logic [31:0] rs2,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  operation_e  ld_op,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [31:0] sh;

    // Bring the addressed byte/halfword down to bit 0 before extension.
    assign sh = rdata >> {ld_off, 3'b000};

    always_comb begin
        be = st_op == OP_SB ? 4'b0001 << st_off :
             st_op == OP_SH ? (st_off[1] ? 4'b1100 : 4'b0011) :
             st_op == OP_SW ? 4'b1111 : 4'b0000;
        wdata = st_op == OP_SB ? {4{rs2[7:0]}} :
                st_op == OP_SH ? {2{rs2[15:0]}} : rs2;
        load_data = ld_op == OP_LB  ? {{24{sh[7]}}, sh[7:0]} :
                    ld_op == OP_LBU ? {24'd0, sh[7:0]} :
                    ld_op == OP_LH  ? {{16{sh[15]}}, sh[15:0]} :
                    ld_op == OP_LHU ? {16'd0, sh[15:0]} :
                    ld_op == OP_LW  ? rdata : sh;
    end

endmodule

// File: rtl/kamus_mem_stage.sv
// kamus_mem_stage: memory pipeline stage; issues L1D requests, waits for grant/response, registers the WB bundle.
// Ports: EX bundle in (valid_i, ex_i, rs2_data_i, operation_i, rd_addr_i, l1d_wr_en_i, regfile_wr_en_i,
// wb_mux_sel_i); stall_o upstream; dmem_* request/response; WB bundle out (wb_valid_o ... misaligned_o).
module kamus_mem_stage
    import kamus_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    input  logic [31:0]   ex_i,
    input  logic [31:0]   rs2_data_i,
    input  logic [5:0]    operation_i,
    input  logic [4:0]    rd_addr_i,
    input  logic          l1d_wr_en_i,
    input  logic          regfile_wr_en_i,
    input  logic [1:0]    wb_mux_sel_i,
    output logic          stall_o,
    output logic          dmem_req_o,
    output logic          dmem_we_o,
    output logic [AW-1:0] dmem_addr_o,
    output logic [3:0]    dmem_be_o,
    output logic [31:0]   dmem_wdata_o,
    input  logic          dmem_gnt_i,
    input  logic          dmem_rvalid_i,
    input  logic [31:0]   dmem_rdata_i,
    output logic          wb_valid_o,
    output logic [4:0]    rd_addr_o,
    output logic          regfile_wr_en_o,
    output logic [1:0]    wb_mux_sel_o,
    output logic [31:0]   alu_result_o,
    output logic [31:0]   load_data_o,
    output logic          misaligned_o
);

    operation_e op, op_q;
    mem_state_t state, state_nx;
    logic [1:0]  off_q;
    logic        ld, st, mem_op, mis, issue, gnt_ev, rsp_ev, mis_ev, done;
    logic [3:0]  be;
    logic [31:0] wdata, ext;

    assign op     = operation_e'(operation_i);
    assign ld     = is_load(op);
    assign st     = is_store(op);
    assign mem_op = ld | st;
    assign mis    = is_misaligned(op, ex_i[1:0]);

    // The EX bundle is held by stall_o while in REQ, so the request is driven straight from it;
    // reset gating makes the request drop immediately on an asynchronous reset.
    assign issue  = !rst_i && ((state == ST_IDLE && valid_i && mem_op && !mis) || state == ST_REQ);
    assign gnt_ev = issue && dmem_gnt_i;
    assign rsp_ev = state == ST_RSP && dmem_rvalid_i;
    assign mis_ev = state == ST_IDLE && valid_i && mem_op && mis;
    assign done   = (state == ST_IDLE && valid_i && !mem_op) || mis_ev || (gnt_ev && st) || rsp_ev;

    assign stall_o  = (issue && !(gnt_ev && st)) || (state == ST_RSP && !dmem_rvalid_i);
    assign state_nx = issue ? (dmem_gnt_i ? (ld ? ST_RSP : ST_IDLE) : ST_REQ) :
                      (state == ST_RSP && !dmem_rvalid_i) ? ST_RSP : ST_IDLE;

    assign dmem_req_o   = issue;
    assign dmem_we_o    = issue && l1d_wr_en_i;
    assign dmem_addr_o  = issue ? {ex_i[AW-1:2], 2'b00} : '0;
    assign dmem_be_o    = issue ? be : 4'b0000;
    assign dmem_wdata_o = issue ? wdata : 32'd0;

    kamus_lsu_align u_align (
        .st_op     (op),
        .st_off    (ex_i[1:0]),
        .rs2       (rs2_data_i),
        .be        (be),
        .wdata     (wdata),
        .ld_op     (op_q),
        .ld_off    (off_q),
        .rdata     (dmem_rdata_i),
        .load_data (ext)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= ST_IDLE;
            off_q           <= 2'b00;
            op_q            <= OP_NOP;
            wb_valid_o      <= 1'b0;
            rd_addr_o       <= 5'd0;
            regfile_wr_en_o <= 1'b0;
            wb_mux_sel_o    <= 2'd0;
            alu_result_o    <= 32'd0;
            load_data_o     <= 32'd0;
            misaligned_o    <= 1'b0;
        end else begin
            state        <= state_nx;
            wb_valid_o   <= done;
            misaligned_o <= mis_ev;
            if (gnt_ev && ld) begin
                off_q <= ex_i[1:0];
                op_q  <= op;
            end
            if (done) begin
                rd_addr_o       <= rd_addr_i;
                regfile_wr_en_o <= regfile_wr_en_i && !mis_ev && !(gnt_ev && st);
                wb_mux_sel_o    <= wb_mux_sel_i;
                alu_result_o    <= ex_i;
            end
            if (rsp_ev)
                load_data_o <= ext;
        end
    end

endmodule
